// File: rtl/xorshift_stream_gen.sv
// xorshift_stream_gen
//   Single-clock xorshift random-number stream generator. A seed and a count are
//   latched on in_valid while idle. The generator then produces one xorshift step
//   per cycle into a show-ahead FIFO. Results leave in generation order through a
//   valid/ready port with backpressure.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   seed/count strobe, sampled only while idle
//   seed       in   initial state (0 is replaced by 1)
//   in_count   in   numbers to produce (0 or > NUM_OUT means NUM_OUT)
//   out_ready  in   consumer accepts rand_num this cycle
//   out_valid  out  rand_num holds a buffered result
//   rand_num   out  FIFO head, 0 while out_valid is low
//   busy       out  high while generating or draining
//   done       out  one-cycle pulse once the last number has been popped
module xorshift_stream_gen #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_OUT    = 256,
  parameter int unsigned SH_A       = 13,
  parameter int unsigned SH_B       = 17,
  parameter int unsigned SH_C       = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(NUM_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] in_count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] rand_num,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StDrain
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] w_x_next;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_rem_next;
  logic [CNT_W-1:0] w_eff_count;
  logic [WIDTH-1:0] w_t1;
  logic [WIDTH-1:0] w_t2;
  logic [WIDTH-1:0] w_step;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [OccW-1:0]  r_occ;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  // One xorshift step; every shift truncates to WIDTH bits.
  always_comb begin
    w_t1   = r_x ^ (r_x << SH_A);
    w_t2   = w_t1 ^ (w_t1 >> SH_B);
    w_step = w_t2 ^ (w_t2 << SH_C);
  end

  always_comb begin
    if (in_count == '0 || in_count > CNT_W'(NUM_OUT)) begin
      w_eff_count = CNT_W'(NUM_OUT);
    end else begin
      w_eff_count = in_count;
    end
  end

  // Full/empty come from the registered occupancy only, so the push decision never
  // depends on out_ready within the same cycle.
  assign w_full  = (r_occ == OccW'(FIFO_DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_pop   = !w_empty && out_ready;

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_rem_next   = r_rem;
    w_push       = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          // An all-zero state would lock the generator at zero.
          w_x_next     = (seed == '0) ? WIDTH'(1) : seed;
          w_rem_next   = w_eff_count;
          w_state_next = StGen;
        end
      end
      StGen: begin
        // When full, x and rem hold so no step is skipped.
        if (!w_full) begin
          w_push     = 1'b1;
          w_x_next   = w_step;
          w_rem_next = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        // Empty implies no pop can be pending this cycle.
        if (w_empty) begin
          done         = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_x      <= '0;
      r_rem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_rem   <= w_rem_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_occ <= r_occ + OccW'(w_push) - OccW'(w_pop);
    end
  end

  // Storage needs no reset: contents are only visible through a non-zero occupancy.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= w_step;
    end
  end

  assign out_valid = !w_empty;
  assign rand_num  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_xorshift_stream_gen.sv
// tb_xorshift_stream_gen
//   Self-checking bench for xorshift_stream_gen with default parameters. Expected
//   numbers are pushed to exp_q when a run is started; observed pops are gathered
//   into obs_q and each scenario task compares the two queues in order.
module tb_xorshift_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] seed;
  logic [8:0]  in_count;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] rand_num;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  xorshift_stream_gen dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .seed     (seed),
    .in_count (in_count),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .rand_num (rand_num),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // Pushes n_exp model values to the scoreboard, then strobes in_valid for one cycle.
  task automatic start_run(input logic [31:0] s, input logic [8:0] cnt, input int n_exp);
    logic [31:0] x;
    x = (s == 32'd0) ? 32'd1 : s;
    for (int i = 0; i < n_exp; i++) begin
      x = model_step(x);
      exp_q.push_back(x);
    end
    @(negedge clk);
    seed     = s;
    in_count = cnt;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Observes the output port (no comparisons here): records pops into obs_q, counts
  // done pulses and hold/zero-output rule violations. out_ready is 0 for the first
  // `stall` cycles. Returns after done + 3 cycles or after stop_pops pops.
  task automatic collect(input int max_cyc, input int stall, input int stop_pops,
                         output int dones, output int rule_err,
                         output logic [31:0] head_at_stall, output bit timed_out);
    int          after;
    bit          hold;
    logic [31:0] hold_val;
    dones         = 0;
    rule_err      = 0;
    head_at_stall = '0;
    timed_out     = 1'b1;
    after         = 0;
    hold          = 1'b0;
    hold_val      = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      out_ready = (c >= stall);
      if (hold && (!out_valid || rand_num !== hold_val)) rule_err++;
      if (!out_valid && rand_num !== 32'd0) rule_err++;
      if (c == stall - 1) head_at_stall = rand_num;
      if (done) dones++;
      hold     = out_valid && !out_ready;
      hold_val = rand_num;
      if (out_valid && out_ready) begin
        obs_q.push_back(rand_num);
        if (stop_pops != 0 && obs_q.size() == stop_pops) begin
          timed_out = 1'b0;
          return;
        end
      end
      if (dones > 0) after++;
      if (after >= 3) begin
        out_ready = 1'b0;
        timed_out = 1'b0;
        return;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    seed      = '0;
    in_count  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total += 4;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b need 0", out_valid);
    else n_pass++;
    if (rand_num !== 32'd0) $display("FAIL reset_rand_num got %h need 0", rand_num);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b need 0", busy);
    else n_pass++;
    if (done !== 1'b0) $display("FAIL reset_done got %b need 0", done);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dones, rule_err; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back(32'h0004_2021);
    exp_q.push_back(32'h0408_0601);
    exp_q.push_back(32'h9DCC_A8C5);
    start_run(32'd1, 9'd3, 0);
    collect(100, 0, 0, dones, rule_err, head, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL basic_value got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL basic_value got %h need %h", g, e);
        else n_pass++;
      end
    end
    n_total += 5;
    if (obs_q.size() != 0) $display("FAIL basic_extra got %0d need 0", obs_q.size());
    else n_pass++;
    if (to) $display("FAIL basic_timeout got timeout need done");
    else n_pass++;
    if (dones != 1) $display("FAIL basic_done_count got %0d need 1", dones);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL basic_busy_end got %b need 0", busy);
    else n_pass++;
    if (rule_err != 0) $display("FAIL basic_rules got %0d need 0", rule_err);
    else n_pass++;
  endtask

  task automatic test_seed_zero();
    int dones, rule_err; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back(32'h0004_2021);
    exp_q.push_back(32'h0408_0601);
    start_run(32'd0, 9'd2, 0);
    collect(100, 0, 0, dones, rule_err, head, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL seed0_value got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL seed0_value got %h need %h", g, e);
        else n_pass++;
      end
    end
    n_total += 2;
    if (obs_q.size() != 0) $display("FAIL seed0_extra got %0d need 0", obs_q.size());
    else n_pass++;
    if (to || dones != 1) $display("FAIL seed0_done got %0d timeout %0b need 1", dones, to);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int dones, rule_err; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    start_run(32'd1, 9'd20, 20);
    collect(200, 15, 0, dones, rule_err, head, to);
    n_total += 2;
    if (head !== 32'h0004_2021) $display("FAIL bp_head got %h need 00042021", head);
    else n_pass++;
    if (rule_err != 0) $display("FAIL bp_hold_rules got %0d need 0", rule_err);
    else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL bp_value got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL bp_value got %h need %h", g, e);
        else n_pass++;
      end
    end
    n_total += 2;
    if (obs_q.size() != 0) $display("FAIL bp_extra got %0d need 0", obs_q.size());
    else n_pass++;
    if (to || dones != 1) $display("FAIL bp_done got %0d timeout %0b need 1", dones, to);
    else n_pass++;
  endtask

  task automatic test_count_zero();
    int dones, rule_err, n_err; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    start_run(32'hDEAD_BEEF, 9'd0, 256);
    collect(800, 0, 0, dones, rule_err, head, to);
    n_total += 1;
    if (obs_q.size() != 256) $display("FAIL cnt0_pops got %0d need 256", obs_q.size());
    else n_pass++;
    n_err = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (obs_q.size() > 0) ? obs_q.pop_front() : ~e;
      if (g !== e) n_err++;
    end
    n_total += 3;
    if (n_err != 0) $display("FAIL cnt0_values got %0d wrong need 0", n_err);
    else n_pass++;
    if (to || dones != 1) $display("FAIL cnt0_done got %0d timeout %0b need 1", dones, to);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL cnt0_busy_end got %b need 0", busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones, rule_err; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    start_run(32'd1, 9'd10, 10);
    // Second strobe while the first stream is generating must be ignored.
    @(negedge clk);
    seed     = 32'd5;
    in_count = 9'd3;
    in_valid = 1'b1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_busy got %b need 1", busy);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    collect(200, 0, 0, dones, rule_err, head, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL b2b_value got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL b2b_value got %h need %h", g, e);
        else n_pass++;
      end
    end
    n_total += 2;
    if (obs_q.size() != 0) $display("FAIL b2b_extra got %0d need 0", obs_q.size());
    else n_pass++;
    if (to || dones != 1) $display("FAIL b2b_done got %0d timeout %0b need 1", dones, to);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int dones, rule_err, late_done; logic [31:0] head, e, g; bit to;
    exp_q.delete(); obs_q.delete();
    start_run(32'd1, 9'd10, 10);
    collect(100, 0, 4, dones, rule_err, head, to);
    rst       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL mrst_value got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL mrst_value got %h need %h", g, e);
        else n_pass++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    n_total += 3;
    if (to) $display("FAIL mrst_timeout got timeout need 4 pops");
    else n_pass++;
    if (out_valid !== 1'b0) $display("FAIL mrst_out_valid got %b need 0", out_valid);
    else n_pass++;
    if (busy !== 1'b0) $display("FAIL mrst_busy got %b need 0", busy);
    else n_pass++;
    late_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) late_done++;
      @(negedge clk);
    end
    n_total++;
    if (late_done != 0) $display("FAIL mrst_no_done got %0d need 0", late_done);
    else n_pass++;
    exp_q.delete(); obs_q.delete();
    exp_q.push_back(32'h0004_2021);
    exp_q.push_back(32'h0408_0601);
    start_run(32'd1, 9'd2, 0);
    collect(100, 0, 0, dones, rule_err, head, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_total++;
      if (obs_q.size() == 0) $display("FAIL mrst_restart got none need %h", e);
      else begin
        g = obs_q.pop_front();
        if (g !== e) $display("FAIL mrst_restart got %h need %h", g, e);
        else n_pass++;
      end
    end
    n_total++;
    if (to || dones != 1) $display("FAIL mrst_done got %0d timeout %0b need 1", dones, to);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_seed_zero();
    test_backpressure();
    test_count_zero();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
